instr_dispatcher: RTL

Upstream feeder for the snooping bus controller; replaces its hard-coded instruction list.
- Buffers 32-bit CPU instructions loaded by the testbench/loader in a FIFO.
- Validates each instruction, then presents one at a time to the bus controller with an issue handshake.
- Holds off the next instruction until the bus reports completion of the current one.
- Keeps issue, error and timeout statistics.

---
 rtl/dispatch_pkg.sv | 46 ++++
 rtl/sync_fifo.sv | 61 ++++++
 rtl/instr_dispatcher.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/dispatch_pkg.sv
// Shared encodings for the instruction dispatcher: CPU ids, ops, field positions, FSM states.
package dispatch_pkg;

    localparam logic [1:0] CPU_P0   = 2'b00;
    localparam logic [1:0] CPU_P1   = 2'b01;
    localparam logic [1:0] CPU_P3   = 2'b11;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b10;

    localparam int unsigned CPU_MSB  = 31;
    localparam int unsigned CPU_LSB  = 30;
    localparam int unsigned OP_MSB   = 29;
    localparam int unsigned OP_LSB   = 28;
    localparam int unsigned TAG_MSB  = 27;
    localparam int unsigned TAG_LSB  = 16;
    localparam int unsigned DATA_MSB = 15;
    localparam int unsigned DATA_LSB = 0;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StBusy  = 2'd2
    } disp_state_e;

    function automatic logic instr_is_valid(input logic [1:0] cpu, input logic [1:0] op);
        logic cpu_ok;
        logic op_ok;
        cpu_ok = (cpu == CPU_P0) || (cpu == CPU_P1) || (cpu == CPU_P3);
        op_ok  = (op == OP_READ) || (op == OP_WRITE);
        return cpu_ok && op_ok;
    endfunction

    // P3 maps onto bit 2; there is no P2 target.
    function automatic logic [2:0] cpu_onehot(input logic [1:0] cpu);
        logic [2:0] sel;
        sel = 3'b000;
        unique case (cpu)
            CPU_P0:  sel = 3'b001;
            CPU_P1:  sel = 3'b010;
            CPU_P3:  sel = 3'b100;
            default: sel = 3'b000;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers for full/empty and a synchronous clear.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clear_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

    // Clear dominates: a same-cycle push or pop is discarded.
    assign do_push = push_i && !full_o && !clear_i;
    assign do_pop  = pop_i && !empty_o && !clear_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/instr_dispatcher.sv
// Buffers loader instructions, drops malformed ones, and issues one at a time to the bus
// controller with a completion handshake, watchdog and statistics.
module instr_dispatcher
    import dispatch_pkg::*;
#(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CW      = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     load_valid,
    input  logic [31:0]              load_instr,
    output logic                     load_ready,
    input  logic                     flush,
    output logic                     issue_valid,
    input  logic                     issue_ack,
    input  logic                     bus_done,
    output logic [31:0]              instruction,
    output logic [2:0]               cpu_sel,
    output logic                     is_write,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     busy,
    output logic                     err_pulse,
    output logic                     timeout_pulse,
    output logic                     spurious_done,
    output logic [CW-1:0]            issued_count,
    output logic [CW-1:0]            error_count
);

    localparam int unsigned WW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    disp_state_e   state_q, state_d;
    logic [31:0]   instr_q, instr_d;
    logic [2:0]    sel_q, sel_d;
    logic          wr_q, wr_d;
    logic [WW-1:0] wdog_q, wdog_d;
    logic [CW-1:0] issued_q, issued_d;
    logic [CW-1:0] error_q, error_d;
    logic          spur_q, spur_d;

    logic [31:0]   fifo_head;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_pop;

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clock),
        .rst_ni  (reset),
        .clear_i (flush),
        .push_i  (load_valid),
        .data_i  (load_instr),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        state_d       = state_q;
        instr_d       = instr_q;
        sel_d         = sel_q;
        wr_d          = wr_q;
        wdog_d        = wdog_q;
        issued_d      = issued_q;
        error_d       = error_q;
        spur_d        = spur_q | (bus_done && (state_q == StIdle));
        fifo_pop      = 1'b0;
        err_pulse     = 1'b0;
        timeout_pulse = 1'b0;

        unique case (state_q)
            StIdle: begin
                // A flushing FIFO has no head worth consuming this cycle.
                if (!fifo_empty && !flush) begin
                    fifo_pop = 1'b1;
                    if (instr_is_valid(fifo_head[CPU_MSB:CPU_LSB], fifo_head[OP_MSB:OP_LSB])) begin
                        instr_d = fifo_head;
                        sel_d   = cpu_onehot(fifo_head[CPU_MSB:CPU_LSB]);
                        wr_d    = (fifo_head[OP_MSB:OP_LSB] == OP_WRITE);
                        state_d = StIssue;
                    end else begin
                        err_pulse = 1'b1;
                        error_d   = error_q + CW'(1);
                    end
                end
            end
            StIssue: begin
                if (bus_done) begin
                    issued_d = issued_q + CW'(1);
                    state_d  = StIdle;
                end else if (issue_ack) begin
                    wdog_d  = WW'(1);
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (bus_done) begin
                    issued_d = issued_q + CW'(1);
                    state_d  = StIdle;
                end else if ((TIMEOUT != 0) && (wdog_q == WW'(TIMEOUT))) begin
                    timeout_pulse = 1'b1;
                    error_d       = error_q + CW'(1);
                    state_d       = StIdle;
                end else begin
                    wdog_d = wdog_q + WW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            instr_q  <= '0;
            sel_q    <= '0;
            wr_q     <= 1'b0;
            wdog_q   <= '0;
            issued_q <= '0;
            error_q  <= '0;
            spur_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            instr_q  <= instr_d;
            sel_q    <= sel_d;
            wr_q     <= wr_d;
            wdog_q   <= wdog_d;
            issued_q <= issued_d;
            error_q  <= error_d;
            spur_q   <= spur_d;
        end
    end

    assign load_ready    = !fifo_full;
    assign issue_valid   = (state_q == StIssue);
    assign busy          = (state_q != StIdle);
    assign instruction   = instr_q;
    assign cpu_sel       = sel_q;
    assign is_write      = wr_q;
    assign spurious_done = spur_q;
    assign issued_count  = issued_q;
    assign error_count   = error_q;

endmodule
